// File: rtl/dffsn_bank_preset_ctrl.sv
// Preset sequencer for a bank of SETN flop groups: pulses one selected group at a time with a gap between groups.
// Optional QMON verify step after each pulse is built when DFFSN_PRESET_VERIFY_EN is defined.
module dffsn_bank_preset_ctrl #(
  parameter int NGRP      = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [NGRP-1:0] mask,
  input  logic [NGRP-1:0] qmon,
  output logic [NGRP-1:0] setn,
  output logic            busy,
  output logic            done,
  output logic            err
);

  // state   | meaning
  // S_IDLE  | waiting for req
  // S_PULSE | setn[g] low, counting pulse width
  // S_CHECK | one all-high cycle, qmon[g] sampled (verify builds only)
  // S_GAP   | all setn high, counting gap width
  // S_FIN   | one-cycle done
  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
`ifdef DFFSN_PRESET_VERIFY_EN
    S_CHECK = 3'd2,
`endif
    S_GAP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d, first_g, nxt_g;
  logic [7:0]      cnt_q, cnt_d;
  logic [NGRP-1:0] msk_q, setn_d;
  logic            nxt_found, grp_end, accept;

  assign accept = (state_q == S_IDLE) && req;

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    first_g   = '0;
    nxt_g     = g_q;
    nxt_found = 1'b0;
    for (int i = NGRP - 1; i >= 0; i--) begin
      if (mask[i]) first_g = GW'(i);
      if (msk_q[i] && (i > int'(g_q))) begin
        nxt_g     = GW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    grp_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (mask == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_PULSE;
            g_d     = first_g;
            cnt_d   = PULSE_LD;
          end
        end
      end
      S_PULSE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
`ifdef DFFSN_PRESET_VERIFY_EN
          state_d = S_CHECK;
`else
          if (GAP_CYC == 0) begin
            grp_end = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
`endif
        end
      end
`ifdef DFFSN_PRESET_VERIFY_EN
      S_CHECK: begin
        if (GAP_CYC == 0) begin
          grp_end = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
      end
`endif
      S_GAP: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               grp_end = 1'b1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (grp_end) begin
      if (nxt_found) begin
        state_d = S_PULSE;
        g_d     = nxt_g;
        cnt_d   = PULSE_LD;
      end else begin
        state_d = S_FIN;
      end
    end
  end

  always_comb begin
    setn_d = '1;
    if (state_q == S_PULSE) setn_d[g_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      msk_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      if (accept) msk_q <= mask;
    end
  end

  // Outputs are a registered decode of the state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      setn <= '1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      setn <= setn_d;
      busy <= (state_q != S_IDLE) && (state_q != S_FIN);
      done <= (state_q == S_FIN);
    end
  end

`ifdef DFFSN_PRESET_VERIFY_EN
  // qmon is sampled while the CHECK cycle is visible on setn, after the pulse has settled.
  logic          chk_q;
  logic [GW-1:0] chk_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
      chk_g <= '0;
      err   <= 1'b0;
    end else begin
      chk_q <= (state_q == S_CHECK);
      chk_g <= g_q;
      if (accept)                     err <= 1'b0;
      else if (chk_q && !qmon[chk_g]) err <= 1'b1;
    end
  end
`else
  logic unused_qmon;
  assign unused_qmon = ^qmon;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dffsn_bank_preset_ctrl.sv
// Directed bench for dffsn_bank_preset_ctrl: default instance plus a GAP_CYC=0 instance for back-to-back requests.
// Verify-step scenario is compiled in when DFFSN_PRESET_VERIFY_EN is defined.
module tb_dffsn_bank_preset_ctrl;

`ifdef DFFSN_PRESET_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif
  localparam int SP_N = 8 + 2 * V;
  localparam int BB_N = 5 + V;

  logic       clk = 1'b0;
  logic       rst, req, req2;
  logic [3:0] mask, mask2, qmon;
  logic [3:0] setn, setn2;
  logic       busy, done, err, busy2, done2, err2;
  int         checks = 0;
  int         failures = 0;

`ifdef DFFSN_PRESET_VERIFY_EN
  logic [3:0] sp_setn [SP_N] = '{4'hD, 4'hD, 4'hF, 4'hF, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
  logic       sp_busy [SP_N] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  logic       sp_done [SP_N] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [3:0] bb_setn [BB_N] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hE};
  logic       bb_busy [BB_N] = '{1, 1, 1, 0, 0, 1};
  logic       bb_done [BB_N] = '{0, 0, 0, 1, 0, 0};
`else
  logic [3:0] sp_setn [SP_N] = '{4'hD, 4'hD, 4'hF, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
  logic       sp_busy [SP_N] = '{1, 1, 1, 1, 1, 1, 0, 0};
  logic       sp_done [SP_N] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic [3:0] bb_setn [BB_N] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hE};
  logic       bb_busy [BB_N] = '{1, 1, 0, 0, 1};
  logic       bb_done [BB_N] = '{0, 0, 1, 0, 0};
`endif

  always #5 clk = ~clk;

  dffsn_bank_preset_ctrl #(.NGRP(4), .PULSE_CYC(2), .GAP_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .qmon(qmon),
    .setn(setn), .busy(busy), .done(done), .err(err)
  );

  dffsn_bank_preset_ctrl #(.NGRP(4), .PULSE_CYC(2), .GAP_CYC(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .req(req2), .mask(mask2), .qmon(qmon),
    .setn(setn2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req2 = 1'b1; mask = 4'hF; mask2 = 4'h1; qmon = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({setn, busy, done, err} !== {4'hF, 3'b000}) begin
        failures++;
        $display("FAIL reset_main cyc%0d setn=%h busy=%b done=%b err=%b want f 0 0 0", i, setn, busy, done, err);
      end
      checks++;
      if ({setn2, busy2, done2, err2} !== {4'hF, 3'b000}) begin
        failures++;
        $display("FAIL reset_g0 cyc%0d setn=%h busy=%b done=%b err=%b want f 0 0 0", i, setn2, busy2, done2, err2);
      end
    end
    rst = 1'b0; req = 1'b0; req2 = 1'b0;
    step();
    checks++;
    if ({setn, busy, done} !== {4'hF, 2'b00}) begin
      failures++;
      $display("FAIL idle_after_reset setn=%h busy=%b done=%b want f 0 0", setn, busy, done);
    end
  endtask

  task automatic test_sparse();
    mask = 4'b1010; req = 1'b1;
    step();
    req = 1'b0; mask = 4'hF;
    checks++;
    if ({setn, busy} !== {4'hF, 1'b0}) begin
      failures++;
      $display("FAIL sparse_accept_lag setn=%h busy=%b want f 0", setn, busy);
    end
    for (int i = 0; i < SP_N; i++) begin
      step();
      if (i == 1) req = 1'b1;
      if (i == 2) req = 1'b0;
      checks++;
      if ({setn, busy, done} !== {sp_setn[i], sp_busy[i], sp_done[i]}) begin
        failures++;
        $display("FAIL sparse cyc%0d setn=%h busy=%b done=%b want %h %b %b",
                 i, setn, busy, done, sp_setn[i], sp_busy[i], sp_done[i]);
      end
    end
  endtask

  task automatic test_empty();
    mask = 4'h0; req = 1'b1;
    step();
    req = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL empty_early_done done=%b want 0", done);
    end
    step();
    checks++;
    if ({setn, busy, done} !== {4'hF, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL empty_done setn=%h busy=%b done=%b want f 0 1", setn, busy, done);
    end
    step();
    checks++;
    if ({setn, busy, done} !== {4'hF, 2'b00}) begin
      failures++;
      $display("FAIL empty_after setn=%h busy=%b done=%b want f 0 0", setn, busy, done);
    end
  endtask

  task automatic test_rst_mid();
    int ndone;
    mask = 4'hF; req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 0; i < 2 * (2 + V + 1) + 1; i++) step();
    checks++;
    if ({setn, busy} !== {4'hB, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_grp2 setn=%h busy=%b want b 1", setn, busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({setn, busy, done, err} !== {4'hF, 3'b000}) begin
      failures++;
      $display("FAIL rst_mid_clear setn=%h busy=%b done=%b err=%b want f 0 0 0", setn, busy, done, err);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({setn, busy, done} !== {4'hF, 2'b00}) begin
      failures++;
      $display("FAIL rst_mid_no_done setn=%h busy=%b done=%b want f 0 0", setn, busy, done);
    end
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    checks++;
    if ({setn, busy} !== {4'hE, 1'b1}) begin
      failures++;
      $display("FAIL rst_mid_restart setn=%h busy=%b want e 1", setn, busy);
    end
    ndone = 0;
    for (int i = 0; i < 4 * (2 + V + 1) + 3; i++) begin
      step();
      if (done) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL rst_mid_full_run done_cycles=%0d want 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    mask2 = 4'b0001; req2 = 1'b1;
    step();
    for (int i = 0; i < BB_N; i++) begin
      step();
      checks++;
      if ({setn2, busy2, done2} !== {bb_setn[i], bb_busy[i], bb_done[i]}) begin
        failures++;
        $display("FAIL back_to_back cyc%0d setn=%h busy=%b done=%b want %h %b %b",
                 i, setn2, busy2, done2, bb_setn[i], bb_busy[i], bb_done[i]);
      end
    end
    req2 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({setn2, busy2, done2} !== {4'hF, 2'b00}) begin
      failures++;
      $display("FAIL back_to_back_drain setn=%h busy=%b done=%b want f 0 0", setn2, busy2, done2);
    end
  endtask

`ifdef DFFSN_PRESET_VERIFY_EN
  task automatic test_verify();
    mask = 4'b0011; qmon = 4'hF; req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 4) begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL verify_grp0_ok err=%b want 0", err);
        end
      end
      if (i == 7) qmon = 4'b1101;
      if (i == 8) begin
        qmon = 4'hF;
        checks++;
        if (err !== 1'b1) begin
          failures++;
          $display("FAIL verify_err_set err=%b want 1", err);
        end
      end
      if (i == 9) begin
        checks++;
        if ({done, err} !== 2'b11) begin
          failures++;
          $display("FAIL verify_done done=%b err=%b want 1 1", done, err);
        end
      end
    end
    req = 1'b1;
    step();
    req = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL verify_err_clear err=%b want 0", err);
    end
    for (int i = 0; i < 12; i++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_sparse();
    test_empty();
    test_rst_mid();
    test_back_to_back();
`ifdef DFFSN_PRESET_VERIFY_EN
    test_verify();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
